// File: rtl/fcc_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fcc_frame_sequencer
// Brief    : Adds raster row/col to a coordinate-free point stream, feeds
//            fcc_top through one registered valid/ready stage and counts its
//            output beats to detect end of frame. Defining FCC_SEQ_TIMEOUT_EN
//            adds a drain watchdog with a TIMEOUT parameter.
// Revision : 1.0  initial release
// ============================================================================
module fcc_frame_sequencer #(
   parameter int W     = 16,
   parameter int ROWS  = 30,
   parameter int COLS  = 30,
   parameter int ROW_W = 8,
   parameter int COL_W = 5
`ifdef FCC_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 32768
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   output logic             busy_o,
   output logic             frame_done_o,
   output logic             timeout_err_o,
   output logic [15:0]      frame_cnt_o,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   input  logic [W-1:0]     s_x_i,
   input  logic [W-1:0]     s_y_i,
   input  logic [W-1:0]     s_z_i,
   input  logic             s_is_ground_i,
   output logic             f_in_valid_o,
   input  logic             f_in_ready_i,
   output logic [ROW_W-1:0] f_in_row_o,
   output logic [COL_W-1:0] f_in_col_o,
   output logic [W-1:0]     f_in_x_o,
   output logic [W-1:0]     f_in_y_o,
   output logic [W-1:0]     f_in_z_o,
   output logic             f_in_is_ground_o,
   input  logic             f_out_valid_i
);

   localparam int NPTS  = ROWS * COLS;
   localparam int CNT_W = $clog2(NPTS + 1);
   localparam logic [CNT_W-1:0] NPTS_C     = CNT_W'(NPTS);
   localparam logic [COL_W-1:0] COL_LAST_C = COL_W'(COLS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q;
   logic             busy_q;
   logic             frame_done_q;
   logic             timeout_err_q;
   logic [15:0]      frame_cnt_q;
   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] col_q;
   logic [CNT_W-1:0] in_cnt_q;
   logic [CNT_W-1:0] out_cnt_q;
   logic [CNT_W-1:0] out_cnt_d;
   logic             f_valid_q;
   logic [ROW_W-1:0] f_row_q;
   logic [COL_W-1:0] f_col_q;
   logic [W-1:0]     f_x_q;
   logic [W-1:0]     f_y_q;
   logic [W-1:0]     f_z_q;
   logic             f_gnd_q;

   logic             w_accept;
   logic             w_f_hs;
   logic             w_counting;
   logic             w_wd_hit;

   // The output stage can take a new point when empty or when it drains this cycle.
   assign s_ready_o  = (state_q == S_FEED) && (in_cnt_q < NPTS_C) &&
                       (!f_valid_q || f_in_ready_i);
   assign w_accept   = s_valid_i && s_ready_o;
   assign w_f_hs     = f_valid_q && f_in_ready_i;
   assign w_counting = (state_q == S_FEED) || (state_q == S_DRAIN);

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (w_counting && f_out_valid_i && (out_cnt_q != NPTS_C)) begin
         out_cnt_d = out_cnt_q + CNT_W'(1);
      end
   end

`ifdef FCC_SEQ_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'(TIMEOUT - 1);

   logic [TMO_W-1:0] wd_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q <= '0;
      end else if (state_q != S_DRAIN) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + TMO_W'(1);
      end
   end

   assign w_wd_hit = (wd_q == TMO_LAST_C);
`else
   assign w_wd_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         frame_cnt_q   <= '0;
         row_q         <= '0;
         col_q         <= '0;
         in_cnt_q      <= '0;
         out_cnt_q     <= '0;
         f_valid_q     <= 1'b0;
         f_row_q       <= '0;
         f_col_q       <= '0;
         f_x_q         <= '0;
         f_y_q         <= '0;
         f_z_q         <= '0;
         f_gnd_q       <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         out_cnt_q    <= out_cnt_d;
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q       <= S_FEED;
                  busy_q        <= 1'b1;
                  row_q         <= '0;
                  col_q         <= '0;
                  in_cnt_q      <= '0;
                  out_cnt_q     <= '0;
                  timeout_err_q <= 1'b0;
               end
            end
            S_FEED: begin
               if (w_accept) begin
                  f_valid_q <= 1'b1;
                  f_row_q   <= row_q;
                  f_col_q   <= col_q;
                  f_x_q     <= s_x_i;
                  f_y_q     <= s_y_i;
                  f_z_q     <= s_z_i;
                  f_gnd_q   <= s_is_ground_i;
                  in_cnt_q  <= in_cnt_q + CNT_W'(1);
                  if (col_q == COL_LAST_C) begin
                     col_q <= '0;
                     row_q <= row_q + ROW_W'(1);
                  end else begin
                     col_q <= col_q + COL_W'(1);
                  end
               end else if (w_f_hs) begin
                  f_valid_q <= 1'b0;
               end
               if (w_f_hs && (in_cnt_q == NPTS_C)) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Completion is checked first so it wins over a coincident watchdog expiry.
               if (out_cnt_d == NPTS_C) begin
                  state_q      <= S_DONE;
                  frame_done_q <= 1'b1;
                  frame_cnt_q  <= frame_cnt_q + 16'd1;
               end else if (w_wd_hit) begin
                  state_q       <= S_DONE;
                  frame_done_q  <= 1'b1;
                  frame_cnt_q   <= frame_cnt_q + 16'd1;
                  timeout_err_q <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o           = busy_q;
   assign frame_done_o     = frame_done_q;
   assign timeout_err_o    = timeout_err_q;
   assign frame_cnt_o      = frame_cnt_q;
   assign f_in_valid_o     = f_valid_q;
   assign f_in_row_o       = f_row_q;
   assign f_in_col_o       = f_col_q;
   assign f_in_x_o         = f_x_q;
   assign f_in_y_o         = f_y_q;
   assign f_in_z_o         = f_z_q;
   assign f_in_is_ground_o = f_gnd_q;

endmodule
`default_nettype wire

// File: tb/tb_fcc_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fcc_frame_sequencer
// Brief    : Directed bench for fcc_frame_sequencer with a point-stream model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fcc_frame_sequencer;

   localparam int W     = 16;
   localparam int ROWS  = 30;
   localparam int COLS  = 30;
   localparam int ROW_W = 8;
   localparam int COL_W = 5;
   localparam int NPTS  = ROWS * COLS;
`ifdef FCC_SEQ_TIMEOUT_EN
   localparam int TIMEOUT = 100;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy, frame_done, timeout_err;
   logic [15:0]      frame_cnt;
   logic             s_valid, s_ready, s_is_ground;
   logic [W-1:0]     s_x, s_y, s_z;
   logic             f_in_valid, f_in_ready, f_in_is_ground, f_out_valid;
   logic [ROW_W-1:0] f_in_row;
   logic [COL_W-1:0] f_in_col;
   logic [W-1:0]     f_in_x, f_in_y, f_in_z;

   fcc_frame_sequencer #(
      .W(W), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)
`ifdef FCC_SEQ_TIMEOUT_EN
      , .TIMEOUT(TIMEOUT)
`endif
   ) dut (
      .clk(clk), .rst(rst), .start_i(start), .busy_o(busy),
      .frame_done_o(frame_done), .timeout_err_o(timeout_err), .frame_cnt_o(frame_cnt),
      .s_valid_i(s_valid), .s_ready_o(s_ready), .s_x_i(s_x), .s_y_i(s_y), .s_z_i(s_z),
      .s_is_ground_i(s_is_ground), .f_in_valid_o(f_in_valid), .f_in_ready_i(f_in_ready),
      .f_in_row_o(f_in_row), .f_in_col_o(f_in_col), .f_in_x_o(f_in_x), .f_in_y_o(f_in_y),
      .f_in_z_o(f_in_z), .f_in_is_ground_o(f_in_is_ground), .f_out_valid_i(f_out_valid)
   );

   always #5 clk = ~clk;

   // Model: the frame as a stream of accepted points; row/col derive from the point index.
   typedef struct {
      int           idx;
      logic [W-1:0] x, y, z;
      logic         g;
   } pt_t;
   typedef enum int {M_IDLE, M_FEED, M_DRAIN, M_DONE} mph_t;

   pt_t  pend[$];
   mph_t ph;
   int   n_acc, n_out, m_fcnt, dcyc;
   bit   m_tmo;

   int vectors = 0, miscompares = 0;
   int cyc = 0;
   bit sv_rand, rdy_slow, start_noise, start_req, beats_on;
   int beat_mode;
   int hs_seen, beats_sent, done_seen;
   int first_row, first_col, last_row, last_col, last_hs_cyc, te_cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      bit want;
      @(posedge clk);
      #1;
      cyc++;
      s_valid     = sv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      s_x         = W'($urandom);
      s_y         = W'($urandom);
      s_z         = W'($urandom);
      s_is_ground = 1'($urandom_range(0, 1));
      f_in_ready  = rdy_slow ? ((cyc % 3) == 0) : 1'b1;
      start       = start_req || (start_noise && (ph != M_IDLE) && ($urandom_range(0, 3) == 0));
      start_req   = 1'b0;
      case (beat_mode)
         0:       want = beats_sent < hs_seen;
         1:       want = beats_sent < hs_seen + 5;
         default: want = (beats_sent < hs_seen) && (beats_sent < NPTS - 1);
      endcase
      f_out_valid = beats_on && want;
      if (f_out_valid) beats_sent++;
   endtask

   task automatic sample();
      bit  hs, acc, last, exp_sready;
      pt_t p;
      @(negedge clk);
      if (rst) begin
         ph = M_IDLE; pend.delete(); n_acc = 0; n_out = 0; m_fcnt = 0; m_tmo = 0;
         check("rst_busy", busy, 0);
         check("rst_s_ready", s_ready, 0);
         check("rst_f_in_valid", f_in_valid, 0);
         check("rst_outs", {frame_done, timeout_err, frame_cnt, f_in_row, f_in_col}, 0);
         return;
      end
      exp_sready = (ph == M_FEED) && (n_acc < NPTS) && ((pend.size() == 0) || f_in_ready);
      check("busy", busy, ph != M_IDLE);
      check("s_ready", s_ready, exp_sready);
      check("f_in_valid", f_in_valid, pend.size() != 0);
      if (pend.size() != 0) begin
         check("f_in_row", f_in_row, pend[0].idx / COLS);
         check("f_in_col", f_in_col, pend[0].idx % COLS);
         check("f_in_data", {f_in_x, f_in_y, f_in_z, f_in_is_ground},
               {pend[0].x, pend[0].y, pend[0].z, pend[0].g});
      end
      check("frame_done", frame_done, ph == M_DONE);
      check("frame_cnt", frame_cnt, m_fcnt);
      check("timeout_err", timeout_err, m_tmo);

      if (f_in_valid && f_in_ready) begin
         if (hs_seen == 0) begin first_row = f_in_row; first_col = f_in_col; end
         last_row = f_in_row; last_col = f_in_col; last_hs_cyc = cyc; hs_seen++;
      end
      if (frame_done) done_seen++;
      if (timeout_err && te_cyc < 0) te_cyc = cyc;

      case (ph)
         M_IDLE: if (start) begin
            ph = M_FEED; n_acc = 0; n_out = 0; m_tmo = 0; pend.delete();
         end
         M_FEED: begin
            hs   = (pend.size() != 0) && f_in_ready;
            acc  = s_valid && exp_sready;
            last = hs && (n_acc == NPTS);
            if (f_out_valid && n_out < NPTS) n_out++;
            if (hs) void'(pend.pop_front());
            if (acc) begin
               p.idx = n_acc; p.x = s_x; p.y = s_y; p.z = s_z; p.g = s_is_ground;
               pend.push_back(p);
               n_acc++;
            end
            if (last) begin ph = M_DRAIN; dcyc = 0; end
         end
         M_DRAIN: begin
            if (f_out_valid && n_out < NPTS) n_out++;
            if (n_out == NPTS) begin
               ph = M_DONE; m_fcnt = (m_fcnt + 1) & 16'hFFFF;
            end
`ifdef FCC_SEQ_TIMEOUT_EN
            else if (dcyc == TIMEOUT - 1) begin
               ph = M_DONE; m_tmo = 1; m_fcnt = (m_fcnt + 1) & 16'hFFFF;
            end
`endif
            dcyc++;
         end
         default: ph = M_IDLE;
      endcase
   endtask

   task automatic cycle();
      drive();
      sample();
   endtask

   task automatic begin_frame(input int mode);
      hs_seen = 0; beats_sent = 0; done_seen = 0; te_cyc = -1;
      first_row = -1; first_col = -1; last_row = -1; last_col = -1;
      beat_mode = mode; beats_on = 1'b1; start_req = 1'b1;
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int k = 0;
      int d0 = done_seen;
      while (done_seen == d0 && k < budget) begin
         cycle();
         k++;
      end
      check({tag, "_completed"}, done_seen != d0, 1);
   endtask

   task automatic frame_checks(input string tag, input int exp_fcnt);
      check({tag, "_first_rc"}, {first_row[7:0], first_col[7:0]}, 16'h0000);
      check({tag, "_last_rc"}, {last_row[7:0], last_col[7:0]}, {8'd29, 8'd29});
      check({tag, "_handshakes"}, hs_seen, 900);
      check({tag, "_frame_cnt"}, frame_cnt, exp_fcnt);
      cycle();
      check({tag, "_busy_after_done"}, busy, 0);
      repeat (10) cycle();
      check({tag, "_done_pulses"}, done_seen, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_x = '0; s_y = '0; s_z = '0;
      s_is_ground = 1'b0; f_in_ready = 1'b0; f_out_valid = 1'b0;
      sv_rand = 0; rdy_slow = 0; start_noise = 0; start_req = 0; beats_on = 0; beat_mode = 0;
      hs_seen = 0; beats_sent = 0; done_seen = 0; te_cyc = -1; last_hs_cyc = 0;
      sample();
      drive(); rst = 1'b0; sample();
      repeat (3) cycle();

      // Reset mid-FEED after 450 points
      begin_frame(0);
      for (int k = 0; k < 2000 && hs_seen < 450; k++) cycle();
      check("mid_progress", hs_seen >= 450, 1);
      @(posedge clk); #1; rst = 1'b1; #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_f_in_valid", f_in_valid, 0);
      check("async_rst_s_ready", s_ready, 0);
      check("async_rst_regs", {f_in_row, f_in_col, f_in_x, frame_cnt}, 0);
      sample();
      drive(); rst = 1'b0; sample();

      // Nominal frame, start noise while busy
      begin_frame(0); start_noise = 1;
      run_until_done(3000, "nominal");
      frame_checks("nominal", 1);

      // Backpressure frame
      begin_frame(0); sv_rand = 1; rdy_slow = 1;
      run_until_done(20000, "bp");
      frame_checks("bp", 2);

      // Early and extra out beats
      begin_frame(1); sv_rand = 0; rdy_slow = 0; start_noise = 0;
      run_until_done(3000, "extra");
      frame_checks("extra", 3);
      check("extra_beats_sent", beats_sent, 905);

      // Only 899 out beats returned
      begin_frame(2);
`ifdef FCC_SEQ_TIMEOUT_EN
      run_until_done(3000, "wd");
      check("wd_err_set", timeout_err, 1);
      check("wd_latency", te_cyc - last_hs_cyc, 101);
      check("wd_frame_cnt", frame_cnt, 4);
      repeat (3) cycle();
      begin_frame(0);
      cycle(); cycle();
      check("wd_err_cleared", timeout_err, 0);
      run_until_done(3000, "post_wd");
      check("post_wd_frame_cnt", frame_cnt, 5);
`else
      for (int k = 0; k < 1500; k++) cycle();
      check("stall_no_done", done_seen, 0);
      check("stall_busy", busy, 1);
      check("stall_no_err", timeout_err, 0);
      check("stall_frame_cnt", frame_cnt, 3);
      @(posedge clk); #1; rst = 1'b1; #1;
      check("stall_rst_busy", busy, 0);
      sample();
      drive(); rst = 1'b0; sample();
`endif
      repeat (3) cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
